// File: rtl/uart_pkg.sv
// Shared definitions for uart_fifo_core: parity modes, FSM state encodings,
// and helpers that derive the baud divider and its counter width.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Wide enough for a two-stop-bit period (2*DIV cycles)
  function automatic int unsigned cnt_width(input int unsigned div);
    return $clog2(2 * div + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push is accepted while full if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs and sticky RX error flags.
// Optional macro UART_LOOPBACK_EN adds a 'loopback' port routing TX to RX.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned WORD_LEN    = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        rx_i,
  output logic                        tx_o,
  input  logic [WORD_LEN-1:0]         tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [WORD_LEN-1:0]         rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun_err,
  input  logic                        err_clr
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                        loopback
`endif
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW  = cnt_width(DIV);
  localparam int unsigned BW  = $clog2(WORD_LEN);
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_M1  = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LEN - 1);
  localparam logic          USE_PAR  = (PARITY_MODE != PAR_NONE);
  localparam logic          ODD_BIT  = (PARITY_MODE == PAR_ODD);

  // ---------------- TX path ----------------
  tx_state_t          tx_state;
  logic [CW-1:0]      tx_cnt;
  logic [BW-1:0]      tx_bit;
  logic [WORD_LEN-1:0] tx_shift;
  logic [WORD_LEN-1:0] tx_head;
  logic               tx_par;
  logic               tx_line;
  logic               tx_full;
  logic               tx_empty;
  logic               tx_pop;

  assign tx_pop   = (tx_state == TX_IDLE) && !tx_empty;
  assign tx_ready = !tx_full;

  sync_fifo #(.WIDTH(WORD_LEN), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_par   <= (^tx_head) ^ ODD_BIT;
            tx_line  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: if (tx_cnt == DIV_M1) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_line  <= tx_shift[0];
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_cnt == DIV_M1) begin
          tx_cnt <= '0;
          if (tx_bit == LAST_BIT) begin
            tx_line  <= USE_PAR ? tx_par : 1'b1;
            tx_state <= USE_PAR ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end
        TX_PARITY: if (tx_cnt == DIV_M1) begin
          tx_cnt   <= '0;
          tx_line  <= 1'b1;
          tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_cnt == STOP_M1) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  rx_state_t           rx_state;
  logic [CW-1:0]       rx_cnt;
  logic [BW-1:0]       rx_bit;
  logic [WORD_LEN-1:0] rx_shift;
  logic                rx_src;
  logic                rx_meta;
  logic                rx_sync;
  logic                rx_prev;
  logic                rx_push;
  logic                rx_full;
  logic                rx_empty;

  assign rx_valid = !rx_empty;

`ifdef UART_LOOPBACK_EN
  logic loop_active;

  // Mode only changes when neither direction is mid-frame
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) loop_active <= 1'b0;
    else if (tx_state == TX_IDLE && rx_state == RX_IDLE) loop_active <= loopback;
  end

  assign rx_src = loop_active ? tx_line : rx_i;
  assign tx_o   = loop_active ? 1'b1 : tx_line;
`else
  assign rx_src = rx_i;
  assign tx_o   = tx_line;
`endif

  sync_fifo #(.WIDTH(WORD_LEN), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_push     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_push <= 1'b0;
      rx_cnt  <= rx_cnt + 1'b1;

      // Clear first so that an error raised below in the same cycle wins
      if (err_clr) begin
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (rx_push && rx_full && !rx_ready) overrun_err <= 1'b1;

      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_M1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == DIV_M1) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_sync, rx_shift[WORD_LEN-1:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == LAST_BIT) rx_state <= USE_PAR ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_cnt == DIV_M1) begin
          rx_cnt <= '0;
          if (((^rx_shift) ^ rx_sync) != ODD_BIT) parity_err <= 1'b1;
          rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == DIV_M1) begin
          rx_cnt <= '0;
          if (rx_sync) begin
            rx_push  <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            frame_err <= 1'b1;
            rx_state  <= RX_BREAK;
          end
        end
        RX_BREAK: begin
          rx_cnt <= '0;
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed self-checking bench: an 8N1 instance (u_a) and an even-parity
// instance (u_p), both DIV=10 with 4-entry FIFOs.
module tb_uart_fifo_core;

  localparam int unsigned DIV = 10;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic err_clr = 1'b0;

  logic       rx_a, tx_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic       perr_a, ferr_a, oerr_a, loop_a, rx_drv_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic [2:0] tx_level_a, rx_level_a;

  logic       tx_p, tx_valid_p, tx_ready_p, rx_valid_p, rx_ready_p;
  logic       perr_p, ferr_p, oerr_p, rx_drv_p;
  logic [7:0] tx_data_p, rx_data_p;
  logic [2:0] tx_level_p, rx_level_p;

  int unsigned total = 0;
  int unsigned passed = 0;

  assign rx_a = loop_a ? tx_a : rx_drv_a;

  always #5 clk = ~clk;

  uart_fifo_core #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WORD_LEN(8),
    .FIFO_DEPTH(4), .PARITY_MODE(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .nreset(nreset), .rx_i(rx_a), .tx_o(tx_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_level(tx_level_a), .rx_level(rx_level_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(oerr_a),
    .err_clr(err_clr)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  uart_fifo_core #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WORD_LEN(8),
    .FIFO_DEPTH(4), .PARITY_MODE(1), .STOP_BITS(1)
  ) u_p (
    .clk(clk), .nreset(nreset), .rx_i(rx_drv_p), .tx_o(tx_p),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .tx_level(tx_level_p), .rx_level(rx_level_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun_err(oerr_p),
    .err_clr(err_clr)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive n line bits LSB first, DIV cycles each, starting at a negedge
  task automatic send_bits(input bit to_p, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (to_p) rx_drv_p = bits[i];
      else      rx_drv_a = bits[i];
      repeat (DIV) @(negedge clk);
    end
    if (to_p) rx_drv_p = 1'b1;
    else      rx_drv_a = 1'b1;
  endtask

  task automatic wait_rx(input bit p, input int unsigned lvl, input int unsigned budget,
                         input string tag);
    int unsigned i = 0;
    while (i < budget && (p ? rx_level_p : rx_level_a) != 3'(lvl)) begin
      @(negedge clk);
      i++;
    end
    check(tag, p ? rx_level_p : rx_level_a, lvl);
  endtask

  task automatic pop_a();
    rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    logic [7:0] d;
    bit saw_low;

    tx_valid_a = 1'b0; tx_data_a = '0; rx_ready_a = 1'b0; loop_a = 1'b0; rx_drv_a = 1'b1;
    tx_valid_p = 1'b0; tx_data_p = '0; rx_ready_p = 1'b0; rx_drv_p = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_o", tx_a, 1);
    check("rst_tx_ready", tx_ready_a, 1);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_tx_level", tx_level_a, 0);
    check("rst_rx_level", rx_level_a, 0);
    check("rst_errs", {perr_a, ferr_a, oerr_a}, 0);
    check("rst_p_tx_o", tx_p, 1);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 on the line: start, 1,0,1,0,0,1,0,1, stop
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    check("tx_level_after_push", tx_level_a, 1);
    repeat (6) @(negedge clk);
    seq = 10'b11_0100_1010;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), tx_a, seq[k]);
      check($sformatf("tx_ready%0d", k), tx_ready_a, 1);
      repeat (DIV) @(negedge clk);
    end
    check("tx_level_drained", tx_level_a, 0);

    // External loop tx->rx, three back-to-back words
    loop_a = 1'b1;
    tx_data_a = 8'h00; tx_valid_a = 1'b1; @(negedge clk);
    tx_data_a = 8'hFF;                    @(negedge clk);
    tx_data_a = 8'h3C;                    @(negedge clk);
    tx_valid_a = 1'b0;
    wait_rx(0, 3, 600, "loop_rx_level");
    check("loop_word0", rx_data_a, 8'h00);
    pop_a();
    check("loop_word1", rx_data_a, 8'hFF);
    pop_a();
    check("loop_word2", rx_data_a, 8'h3C);
    pop_a();
    check("loop_rx_valid_empty", rx_valid_a, 0);
    check("loop_errs", {perr_a, ferr_a, oerr_a}, 0);
    repeat (10) @(negedge clk);
    loop_a = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55 with low stop bit
    send_bits(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("frame_err_set", ferr_a, 1);
    check("frame_no_push", rx_level_a, 0);
    check("frame_no_parity", perr_a, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("frame_err_cleared", ferr_a, 0);

    // One-cycle glitch must not start a frame
    rx_drv_a = 1'b0; @(negedge clk); rx_drv_a = 1'b1;
    repeat (120) @(negedge clk);
    check("glitch_no_push", rx_level_a, 0);
    check("glitch_no_ferr", ferr_a, 0);

    // Even parity: 0x07 needs parity 1, send 0
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    wait_rx(1, 1, 40, "par_rx_level");
    check("par_word", rx_data_p, 8'h07);
    check("par_err_set", perr_p, 1);
    check("par_no_ferr", ferr_p, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("par_err_cleared", perr_p, 0);
    rx_ready_p = 1'b1; @(negedge clk); rx_ready_p = 1'b0;
    // 0x03 has two ones, parity 0 is correct
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    wait_rx(1, 1, 40, "par_ok_rx_level");
    check("par_ok_word", rx_data_p, 8'h03);
    check("par_ok_no_err", perr_p, 0);

    // Five frames into a 4-deep RX FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
    end
    repeat (20) @(negedge clk);
    check("ovr_rx_level", rx_level_a, 4);
    check("ovr_err_set", oerr_a, 1);
    check("ovr_head", rx_data_a, 8'h11);
    check("ovr_no_ferr", ferr_a, 0);

    // Reset in the middle of the second of three frames
    tx_data_a = 8'hFF; tx_valid_a = 1'b1; @(negedge clk);
    tx_data_a = 8'h00;                    @(negedge clk);
    tx_data_a = 8'h00;                    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (150) @(negedge clk);
    check("mid_frame_tx_low", tx_a, 0);
    check("mid_frame_tx_level", tx_level_a, 1);
    nreset = 1'b0;
    @(negedge clk);
    check("abort_tx_high", tx_a, 1);
    check("abort_tx_level", tx_level_a, 0);
    check("abort_rx_level", rx_level_a, 0);
    check("abort_errs", {perr_a, ferr_a, oerr_a}, 0);
    nreset = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) saw_low = 1'b1;
    end
    check("abort_no_more_frames", saw_low, 0);
    check("abort_tx_level_after", tx_level_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
